xylo_pixel_gen: RTL and testbench

- Pixel source for the VGA/DVI output top. Consumes the raster position, blank and vsync from the VGA timing logic; produces the 24-bit RGB pixel the top packs onto the DVI bus.
- Draws 8 xylophone bars on a 640x480 raster. Each bar brightens on a strike and fades once per frame.
- Runs entirely in the 25 MHz pixel clock domain.

---
 rtl/xylo_pixel_gen.sv | 146 ++++++++++++++
 tb/tb_xylo_pixel_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/xylo_pixel_gen.sv
// Xylophone pixel source: eight bars over a 640x480 raster, struck to brighten and faded once per frame.
// Two-stage pipeline from raster position to RGB, all in the pixel clock domain.
module xylo_pixel_gen #(
    parameter int BAR_TOP          = 80,
    parameter int BAR_BOT          = 399,
    parameter int DECAY            = 8,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       blank,
    input  logic       vsync,
    input  logic       strike_valid,
    input  logic [2:0] strike_bar,
    input  logic [7:0] strike_vel,
    output logic [7:0] pixel_r,
    output logic [7:0] pixel_g,
    output logic [7:0] pixel_b,
    output logic       blank_d,
    output logic [7:0] bar_lit
);

    localparam logic [7:0]  DECAY_8    = 8'(DECAY);
    localparam logic        VSYNC_IDLE = (VSYNC_ACTIVE_LOW != 0);
    localparam logic [23:0] BG_RGB     = 24'h101010;

    function automatic logic [23:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFF0000;
            3'd1:    return 24'hFF8000;
            3'd2:    return 24'hFFFF00;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'h00FFFF;
            3'd5:    return 24'h0000FF;
            3'd6:    return 24'h8000FF;
            default: return 24'hFF00FF;
        endcase
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [7:0] decay_sat(input logic [7:0] b);
        return (b > DECAY_8) ? b - DECAY_8 : 8'd0;
    endfunction

    logic [7:0] bright [8];
    logic [7:0] bright_nxt [8];
    logic       vsync_q;
    logic       tick;

    logic [7:0] hit;
    logic       row_ok;
    logic       in_bar;
    logic [2:0] idx;

    logic       in_bar_p1;
    logic [2:0] idx_p1;
    logic       blank_p1;

    logic [23:0] base;
    logic [7:0]  lvl;
    logic [23:0] rgb;

    assign tick = (vsync_q == VSYNC_IDLE) && (vsync != VSYNC_IDLE);

    // Strike takes the max against the (possibly decayed) value so a weak hit never dims a bar
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            bright_nxt[i] = tick ? decay_sat(bright[i]) : bright[i];
            if (strike_valid && (strike_bar == 3'(i)) && (strike_vel > bright_nxt[i]))
                bright_nxt[i] = strike_vel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= VSYNC_IDLE;
            bar_lit <= 8'h00;
            for (int i = 0; i < 8; i++) bright[i] <= 8'h00;
        end else begin
            vsync_q <= vsync;
            for (int i = 0; i < 8; i++) begin
                bright[i]  <= bright_nxt[i];
                bar_lit[i] <= (bright[i] != 8'h00);
            end
        end
    end

    always_comb begin
        row_ok = (pixel_y >= 10'(BAR_TOP)) && (pixel_y <= 10'(BAR_BOT));
        idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            hit[i] = (pixel_x >= 10'(80 * i + 8)) && (pixel_x <= 10'(80 * i + 71));
            if (hit[i]) idx = 3'(i);
        end
        in_bar = row_ok && (|hit);
    end

    // Stage 1: bar hit and index; blank resets high so outputs stay dark until refilled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_bar_p1 <= 1'b0;
            idx_p1    <= 3'd0;
            blank_p1  <= 1'b1;
        end else begin
            in_bar_p1 <= in_bar;
            idx_p1    <= idx;
            blank_p1  <= blank;
        end
    end

    always_comb begin
        base = palette(idx_p1);
        lvl  = bright[idx_p1];
        if (blank_p1)
            rgb = 24'h000000;
        else if (in_bar_p1)
            rgb = {sat_add({2'b00, base[23:18]}, lvl),
                   sat_add({2'b00, base[15:10]}, lvl),
                   sat_add({2'b00, base[7:2]},   lvl)};
        else
            rgb = BG_RGB;
    end

    // Stage 2: colour and aligned blank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_r <= 8'h00;
            pixel_g <= 8'h00;
            pixel_b <= 8'h00;
            blank_d <= 1'b1;
        end else begin
            pixel_r <= rgb[23:16];
            pixel_g <= rgb[15:8];
            pixel_b <= rgb[7:0];
            blank_d <= blank_p1;
        end
    end

endmodule

// File: tb/tb_xylo_pixel_gen.sv
// Directed bench for xylo_pixel_gen: geometry, palette, strikes, frame decay, blanking and async reset.
module tb_xylo_pixel_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       blank;
    logic       vsync;
    logic       strike_valid;
    logic [2:0] strike_bar;
    logic [7:0] strike_vel;
    logic [7:0] pixel_r, pixel_g, pixel_b;
    logic       blank_d;
    logic [7:0] bar_lit;

    int n_cmp = 0;
    int n_bad = 0;

    xylo_pixel_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .blank        (blank),
        .vsync        (vsync),
        .strike_valid (strike_valid),
        .strike_bar   (strike_bar),
        .strike_vel   (strike_vel),
        .pixel_r      (pixel_r),
        .pixel_g      (pixel_g),
        .pixel_b      (pixel_b),
        .blank_d      (blank_d),
        .bar_lit      (bar_lit)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, pixel_r, pixel_g, pixel_b};
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic show(input logic [9:0] x, input logic [9:0] y);
        pixel_x = x;
        pixel_y = y;
        blank   = 1'b0;
        cyc(2);
    endtask

    task automatic strike(input logic [2:0] bar, input logic [7:0] vel);
        strike_valid = 1'b1;
        strike_bar   = bar;
        strike_vel   = vel;
        cyc(1);
        strike_valid = 1'b0;
    endtask

    task automatic frame_tick();
        vsync = 1'b0;
        cyc(3);
        vsync = 1'b1;
        cyc(1);
    endtask

    logic blank_seq [10];

    initial begin
        rst_n = 1'b0; pixel_x = 10'd40; pixel_y = 10'd200; blank = 1'b0;
        vsync = 1'b1; strike_valid = 1'b0; strike_bar = 3'd0; strike_vel = 8'd0;
        cyc(2);
        chk("reset_rgb", rgb(), 32'h000000);
        chk("reset_blank_d", {31'd0, blank_d}, 32'd1);
        chk("reset_bar_lit", {24'd0, bar_lit}, 32'h00);
        rst_n = 1'b1;

        show(10'd40, 10'd200);
        chk("bar0_dim", rgb(), 32'h3F0000);
        chk("bar0_blank_d", {31'd0, blank_d}, 32'd0);
        show(10'd4, 10'd200);
        chk("gap_bg", rgb(), 32'h101010);
        show(10'd40, 10'd50);
        chk("above_bg", rgb(), 32'h101010);

        strike(3'd3, 8'hC0);
        show(10'd280, 10'd200);
        chk("bar3_c0", rgb(), 32'hC0FFC0);
        chk("bar3_lit", {24'd0, bar_lit}, 32'h08);
        frame_tick();
        show(10'd280, 10'd200);
        chk("bar3_tick", rgb(), 32'hB8F7B8);

        strike(3'd3, 8'h40);
        show(10'd280, 10'd200);
        chk("weak_strike", rgb(), 32'hB8F7B8);
        strike(3'd3, 8'hF0);
        show(10'd280, 10'd200);
        chk("strong_strike", rgb(), 32'hF0FFF0);
        show(10'd40, 10'd200);
        chk("bar0_unchanged", rgb(), 32'h3F0000);

        strike(3'd2, 8'h05);
        show(10'd200, 10'd200);
        chk("bar2_05", rgb(), 32'h444405);
        chk("lit_2_3", {24'd0, bar_lit}, 32'h0C);
        frame_tick();
        show(10'd200, 10'd200);
        chk("bar2_decay0", rgb(), 32'h3F3F00);
        chk("lit_3_only", {24'd0, bar_lit}, 32'h08);

        strike(3'd4, 8'h30);
        vsync = 1'b0;
        strike(3'd4, 8'h20);
        cyc(1);
        vsync = 1'b1;
        cyc(1);
        show(10'd360, 10'd200);
        chk("tick_vs_strike", rgb(), 32'h286767);
        show(10'd280, 10'd200);
        chk("bar3_e0", rgb(), 32'hE0FFE0);

        blank = 1'b1;
        cyc(2);
        chk("blank_rgb", rgb(), 32'h000000);
        chk("blank_blank_d", {31'd0, blank_d}, 32'd1);

        for (int k = 0; k < 10; k++) blank_seq[k] = k[0];
        for (int k = 0; k < 10; k++) begin
            if (k >= 2) begin
                chk("toggle_blank_d", {31'd0, blank_d}, {31'd0, blank_seq[k-2]});
                chk("toggle_rgb", rgb(), blank_seq[k-2] ? 32'h000000 : 32'hE0FFE0);
            end
            blank = blank_seq[k];
            cyc(1);
        end

        strike(3'd1, 8'h80);
        strike(3'd5, 8'h80);
        show(10'd120, 10'd200);
        chk("bar1_lit_pre", rgb(), 32'hBFA080);
        #7 rst_n = 1'b0;
        #1;
        chk("async_rgb", rgb(), 32'h000000);
        chk("async_blank_d", {31'd0, blank_d}, 32'd1);
        chk("async_bar_lit", {24'd0, bar_lit}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        chk("refill_rgb", rgb(), 32'h000000);
        chk("refill_blank_d", {31'd0, blank_d}, 32'd1);
        cyc(1);
        chk("bar1_dim_after", rgb(), 32'h3F2000);
        show(10'd440, 10'd200);
        chk("bar5_dim_after", rgb(), 32'h00003F);
        chk("lit_after_reset", {24'd0, bar_lit}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
